uart_instr_loader: RTL and testbench

Receives the program image over the board UART (8N1, LSB first) and assembles byte pairs into 16-bit instruction words. Writes each word into the CPU instruction memory starting at address 1. Declares the transfer complete after a line-idle timeout, so the top level can enable `i_start_cpu`. Sits directly upstream of the instruction memory / control unit inside `TOP_CPU` and drives `o_instr_transmit_done` and `o_max_addr`.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/uart_rx.sv | 122 ++++++++++++
 rtl/uart_instr_loader.sv | 152 +++++++++++++++
 tb/tb_uart_instr_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and state encodings for the UART program loader.
package cpu_pkg;

  localparam int CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_WAIT_HI, LD_WAIT_LO, LD_DONE} ld_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop input synchronizer and mid-bit sampling FSM.
// Emits a one-cycle rx_valid per good frame and rx_frame_err on a low stop bit.
module uart_rx
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = cpu_pkg::CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_start,
  output logic       rx_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             fall;

  assign rx_s     = sync_q[1];
  assign fall     = prev_q & ~rx_s;
  assign rx_idle  = (state_q == RX_IDLE);
  assign rx_start = rx_idle & fall;

  always_comb begin
    sync_d  = {sync_q[0], i_rx};
    prev_d  = rx_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // A line that is high again at mid start bit was a glitch, not a frame.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) begin
            valid_d = 1'b1;
            byte_d  = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte      = byte_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_instr_loader.sv
// Pairs UART bytes into 16-bit instruction words, writes them from START_ADDR
// upward and declares the load complete after a line-idle timeout.
module uart_instr_loader
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT      = cpu_pkg::CLKS_PER_BIT,
  parameter int ADDR_W            = 8,
  parameter int START_ADDR        = 1,
  parameter int IDLE_TIMEOUT_BITS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_instr_transmit_done,
  output logic [ADDR_W-1:0] o_max_addr,
  output logic              o_err
);

  localparam int TMR_LIMIT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMR_W     = $clog2(TMR_LIMIT + 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err, rx_start, rx_idle;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_start    (rx_start),
    .rx_idle     (rx_idle)
  );

  ld_state_e         ld_q, ld_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;
  logic              wrote_q, wrote_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] max_q, max_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmr_full;
  logic              timeout;

  // A start bit arriving on the expiry cycle wins: the line is not idle after all.
  assign tmr_full = (tmr_q == TMR_W'(TMR_LIMIT));
  assign timeout  = rx_idle & tmr_full & ~rx_start & wrote_q;

  always_comb begin
    ld_d    = ld_q;
    tmr_d   = tmr_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    wrote_d = wrote_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    max_d   = max_q;
    done_d  = done_q;
    err_d   = err_q | rx_frame_err;
    if (rx_start)                tmr_d = '0;
    else if (rx_idle && !tmr_full) tmr_d = tmr_q + 1'b1;
    case (ld_q)
      LD_WAIT_HI: begin
        if (rx_valid) begin
          hi_d = rx_byte;
          ld_d = LD_WAIT_LO;
        end else if (timeout) begin
          ld_d   = LD_DONE;
          done_d = 1'b1;
        end
      end
      LD_WAIT_LO: begin
        if (rx_valid) begin
          if (full_q) begin
            err_d  = 1'b1;
            ld_d   = LD_DONE;
            done_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            addr_d  = ptr_q;
            wdata_d = {hi_q, rx_byte};
            max_d   = ptr_q;
            wrote_d = 1'b1;
            ld_d    = LD_WAIT_HI;
            // The top address is still usable; only the word after it is lost.
            if (ptr_q == ADDR_LAST) full_d = 1'b1;
            else                    ptr_d  = ptr_q + 1'b1;
          end
        end else if (timeout) begin
          err_d  = 1'b1;
          ld_d   = LD_DONE;
          done_d = 1'b1;
        end
      end
      LD_DONE: ;
      default: ld_d = LD_WAIT_HI;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_q    <= LD_WAIT_HI;
      tmr_q   <= '0;
      hi_q    <= '0;
      ptr_q   <= ADDR_FIRST;
      full_q  <= 1'b0;
      wrote_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ld_q    <= ld_d;
      tmr_q   <= tmr_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      wrote_q <= wrote_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      max_q   <= max_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_wr_en           = wr_en_q;
  assign o_mem_addr            = addr_q;
  assign o_mem_wdata           = wdata_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_q;
  assign o_err                 = err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: a default-width instance and a 3-bit
// address instance for overflow, both driven at a shortened bit time.
module tb_uart_instr_loader;

  localparam int CPB     = 16;
  localparam int TO_BITS = 16;
  localparam int LIMIT   = CPB * TO_BITS;

  logic        clk;
  logic        rst_n;
  logic        rx_a, rx_b;
  logic        a_wr_en, a_done, a_err;
  logic [7:0]  a_addr, a_max;
  logic [15:0] a_wdata;
  logic        b_wr_en, b_done, b_err;
  logic [2:0]  b_addr, b_max;
  logic [15:0] b_wdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  qa_addr[$];
  logic [15:0] qa_data[$];
  logic [2:0]  qb_addr[$];
  logic [15:0] qb_data[$];

  logic [15:0] prog [15] = '{16'h1101, 16'h1202, 16'h2312, 16'h3403, 16'h4504,
                             16'h5605, 16'h6706, 16'h7807, 16'h8908, 16'h9A09,
                             16'hAB0A, 16'hBC0B, 16'hCD0C, 16'hD00D, 16'hE000};

  uart_instr_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_W(8), .START_ADDR(1), .IDLE_TIMEOUT_BITS(TO_BITS)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a),
    .o_mem_wr_en(a_wr_en), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
    .o_instr_transmit_done(a_done), .o_max_addr(a_max), .o_err(a_err)
  );

  uart_instr_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_W(3), .START_ADDR(1), .IDLE_TIMEOUT_BITS(TO_BITS)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b),
    .o_mem_wr_en(b_wr_en), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
    .o_instr_transmit_done(b_done), .o_max_addr(b_max), .o_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_wr_en) begin
      qa_addr.push_back(a_addr);
      qa_data.push_back(a_wdata);
    end
    if (b_wr_en) begin
      qb_addr.push_back(b_addr);
      qb_data.push_back(b_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  // Frame starts on the next falling clock edge; returns one stop bit later.
  task automatic send_byte(input bit to_b, input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    drive(to_b, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(to_b, data[i]);
      repeat (CPB) @(negedge clk);
    end
    drive(to_b, stop_bit);
    repeat (CPB) @(negedge clk);
    drive(to_b, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en", a_wr_en, 0);
    check("rst_addr",  a_addr,  0);
    check("rst_wdata", a_wdata, 0);
    check("rst_done",  a_done,  0);
    check("rst_max",   a_max,   0);
    check("rst_err",   a_err,   0);
    check("rst_b_done", b_done, 0);
    check("rst_b_max",  b_max,  0);
    rst_n = 1'b1;

    // Single word with exact done latency
    send_byte(0, 8'h41, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    check("t1_wr_count", qa_addr.size(), 1);
    if (qa_addr.size() == 1) begin
      check("t1_addr", qa_addr[0], 1);
      check("t1_data", qa_data[0], 16'h4100);
    end
    repeat (251) @(negedge clk);
    check("t1_done_before", a_done, 0);
    @(negedge clk);
    check("t1_done_at", a_done, 1);
    check("t1_max", a_max, 1);
    check("t1_err", a_err, 0);

    // Full 15-instruction program
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send_byte(0, prog[i][15:8], 1'b1);
      send_byte(0, prog[i][7:0], 1'b1);
    end
    check("prog_wr_count", qa_addr.size(), 15);
    if (qa_addr.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        check($sformatf("prog_addr%0d", i), qa_addr[i], i + 1);
        check($sformatf("prog_data%0d", i), qa_data[i], prog[i]);
      end
    end
    repeat (LIMIT + 20) @(negedge clk);
    check("prog_done", a_done, 1);
    check("prog_max", a_max, 15);
    check("prog_err", a_err, 0);

    // False start, empty timeout, framing error, start-on-expiry priority
    do_reset();
    @(negedge clk);
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (LIMIT + 40) @(negedge clk);
    check("glitch_err", a_err, 0);
    check("glitch_wr_count", qa_addr.size(), 0);
    check("empty_timeout_done", a_done, 0);
    send_byte(0, 8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    check("frame_err", a_err, 1);
    check("frame_wr_count", qa_addr.size(), 0);
    send_byte(0, 8'h12, 1'b1);
    send_byte(0, 8'h34, 1'b1);
    check("frame_next_count", qa_addr.size(), 1);
    if (qa_addr.size() == 1) begin
      check("frame_next_addr", qa_addr[0], 1);
      check("frame_next_data", qa_data[0], 16'h1234);
    end
    repeat (248) @(negedge clk);
    send_byte(0, 8'h56, 1'b1);
    check("prio_done", a_done, 0);
    send_byte(0, 8'h78, 1'b1);
    check("prio_wr_count", qa_addr.size(), 2);
    if (qa_addr.size() == 2) begin
      check("prio_addr", qa_addr[1], 2);
      check("prio_data", qa_data[1], 16'h5678);
    end
    repeat (LIMIT + 20) @(negedge clk);
    check("prio_done_later", a_done, 1);

    // Odd byte count
    do_reset();
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    send_byte(0, 8'hCC, 1'b1);
    check("odd_wr_count", qa_addr.size(), 1);
    if (qa_addr.size() == 1) check("odd_data", qa_data[0], 16'hAABB);
    check("odd_err_before", a_err, 0);
    repeat (LIMIT + 20) @(negedge clk);
    check("odd_done", a_done, 1);
    check("odd_err", a_err, 1);
    check("odd_max", a_max, 1);

    // Reset in the middle of a byte
    do_reset();
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'h66, 1'b1);
    check("midrst_pre_max", a_max, 1);
    @(negedge clk);
    rx_a = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    rx_a  = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_addr",  a_addr,  0);
    check("midrst_wdata", a_wdata, 0);
    check("midrst_max",   a_max,   0);
    check("midrst_wr_en", a_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    qa_addr.delete(); qa_data.delete();
    repeat (CPB * 12) @(negedge clk);
    send_byte(0, 8'h41, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    check("midrst_wr_count", qa_addr.size(), 1);
    if (qa_addr.size() == 1) begin
      check("midrst_new_addr", qa_addr[0], 1);
      check("midrst_new_data", qa_data[0], 16'h4100);
    end
    repeat (LIMIT + 20) @(negedge clk);
    check("midrst_done", a_done, 1);
    check("midrst_err", a_err, 0);

    // Address overflow on the 3-bit instance
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_byte(1, 8'(8'h80 + i), 1'b1);
      send_byte(1, 8'(8'h01 + i), 1'b1);
    end
    repeat (4) @(negedge clk);
    check("ovf_wr_count", qb_addr.size(), 7);
    if (qb_addr.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("ovf_addr%0d", i), qb_addr[i], i + 1);
        check($sformatf("ovf_data%0d", i), qb_data[i], {8'(8'h80 + i), 8'(8'h01 + i)});
      end
    end
    check("ovf_err", b_err, 1);
    check("ovf_done", b_done, 1);
    check("ovf_max", b_max, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
